// File: rtl/scan_defs.sv
// scan_defs: shared definitions for the decoder-line scan sequencer.
//   state_e      - FSM state encoding (IDLE / RUN / DONE)
//   LINES        - number of scanned lines (two 1-of-8 decoders)
//   G1_OFF/G2B_OFF - enable levels that disable a 74HC138
//   outs_t       - bundle of the registered outputs
//   decode_outputs() - maps a state/index pair onto the output bundle
package scan_defs;

  localparam int LINES = 16;
  localparam int IDX_W = 4;

  // Levels that keep a '138 disabled (G1 active high, G2A/G2B active low).
  localparam logic G1_OFF  = 1'b0;
  localparam logic G2B_OFF = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0] num;
    logic       ic0_g1;
    logic       ic0_g2b;
    logic       ic1_g1;
    logic       ic1_g2b;
    logic       busy;
    logic       done;
  } outs_t;

  localparam outs_t OUTS_IDLE = '{
    num:     3'd0,
    ic0_g1:  G1_OFF,
    ic0_g2b: G2B_OFF,
    ic1_g1:  G1_OFF,
    ic1_g2b: G2B_OFF,
    busy:    1'b0,
    done:    1'b0
  };

  // index[3] picks the decoder, so exactly one '138 is enabled in RUN and
  // the hand-over at 7->8 / 15->0 happens in a single registered update.
  function automatic outs_t decode_outputs(input state_e st,
                                           input logic [IDX_W-1:0] idx);
    outs_t o;
    o = OUTS_IDLE;
    if (st == RUN) begin
      o.num  = idx[2:0];
      o.busy = 1'b1;
      if (idx[3]) begin
        o.ic1_g1  = ~G1_OFF;
        o.ic1_g2b = ~G2B_OFF;
      end else begin
        o.ic0_g1  = ~G1_OFF;
        o.ic0_g2b = ~G2B_OFF;
      end
    end else if (st == DONE) begin
      o.done = 1'b1;
    end
    return o;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: per-line dwell counter for the scan sequencer.
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   clear  - forces the count back to zero (used outside RUN and on abort)
//   limit  - terminal count; a line lasts limit+1 cycles
//   expire - high in the last cycle of the current line
// The counter wraps to zero on reaching limit, so it never exceeds limit
// and cannot overflow.
module dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  assign expire = (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clear || expire) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: walks 16 lines across two 74HC138 decoders.
//   clk, rst_n        - clock and asynchronous active-low reset
//   start, stop       - scan request / abort (stop wins when both are high)
//   oneshot           - 1: single pass ending with a done pulse, 0: wrap
//   dwell             - cycles per line minus one
//   num               - shared A/B/C select for both decoders
//   ic0_g1, ic0_g2b   - enables of decoder 0 (lines 0-7)
//   ic1_g1, ic1_g2b   - enables of decoder 1 (lines 8-15)
//   index             - current line number
//   busy, done        - RUN indicator and end-of-pass pulse
// All outputs are registered from the next-state values so they describe
// the state and line of the cycle in which they are seen.
module scan_sequencer #(
  parameter int LINES   = scan_defs::LINES,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               oneshot,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         num,
  output logic               ic0_g1,
  output logic               ic0_g2b,
  output logic               ic1_g1,
  output logic               ic1_g2b,
  output logic [3:0]         index,
  output logic               busy,
  output logic               done
);

  import scan_defs::*;

  localparam logic [IDX_W-1:0] LAST_LINE = IDX_W'(LINES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               oneshot_q, oneshot_d;
  outs_t              outs_q, outs_d;
  logic               timer_clear;
  logic               expire;

  // Held clear whenever we are not scanning, so the first RUN cycle always
  // starts a fresh dwell. Clearing on stop drops the partial line.
  assign timer_clear = (state_q != RUN) || stop;

  dwell_timer #(
    .W(DWELL_W)
  ) u_dwell_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .limit  (dwell_q),
    .expire (expire)
  );

  // State register (plus scan settings captured at start).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      index_q   <= '0;
      dwell_q   <= '0;
      oneshot_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      dwell_q   <= dwell_d;
      oneshot_q <= oneshot_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    dwell_d   = dwell_q;
    oneshot_d = oneshot_q;
    unique case (state_q)
      IDLE: begin
        index_d = '0;
        if (start && !stop) begin
          state_d   = RUN;
          dwell_d   = dwell;
          oneshot_d = oneshot;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          index_d = '0;
        end else if (expire) begin
          if (index_q == LAST_LINE) begin
            index_d = '0;
            if (oneshot_q) begin
              state_d = DONE;
            end
          end else begin
            index_d = index_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        index_d = '0;
      end
      default: begin
        state_d = IDLE;
        index_d = '0;
      end
    endcase
  end

  // Output logic: decoded from the next state so the registered copy lines
  // up with state_q/index_q in the following cycle.
  always_comb begin
    outs_d = decode_outputs(state_d, index_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outs_q <= OUTS_IDLE;
    end else begin
      outs_q <= outs_d;
    end
  end

  assign num     = outs_q.num;
  assign ic0_g1  = outs_q.ic0_g1;
  assign ic0_g2b = outs_q.ic0_g2b;
  assign ic1_g1  = outs_q.ic1_g1;
  assign ic1_g2b = outs_q.ic1_g2b;
  assign busy    = outs_q.busy;
  assign done    = outs_q.done;
  assign index   = index_q;

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter LINES, default 16, is the number of scanned decoder lines (two 1-of-8 decoders); it is fixed at 16.
REQ-002 Parameter DWELL_W, default 8, is the width of the dwell setting.
REQ-003 clk  input  1  is the single rising-edge clock.
REQ-004 rst_n  input  1  is the asynchronous, active-low reset.
REQ-005 start  input  1  is a start-scan request, sampled on the clk rising edge.
REQ-006 stop  input  1  is an abort-scan request, sampled on the clk rising edge.
REQ-007 oneshot  input  1  selects a single pass (1) or continuous wrap (0); it is sampled at start.
REQ-008 dwell  input  DWELL_W  sets the cycles per line minus 1; it is sampled at start.
REQ-009 num  output  3  is the shared line select driven to NumberBit2..0 of both decoders.
REQ-010 ic0_g1  output  1  is the active-high enable (Enable2) of decoder 0, which covers lines 0-7.
REQ-011 ic0_g2b  output  1  is the active-low enable driven to EnableB0 and EnableB1 of decoder 0.
REQ-012 ic1_g1  output  1  is Enable2 of decoder 1, which covers lines 8-15.
REQ-013 ic1_g2b  output  1  is the active-low enable driven to EnableB0 and EnableB1 of decoder 1.
REQ-014 index  output  4  is the current scan line number.
REQ-015 busy  output  1  is high while the FSM is in RUN.
REQ-016 done  output  1  is a one-cycle pulse at the end of a one-shot pass.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-018 IDLE transitions: start=1 and stop=0 -> RUN, with index=0, the dwell counter cleared, and dwell and oneshot latched.
REQ-019 In RUN, the dwell counter SHALL increment every cycle; when it equals the latched dwell value it clears and index advances by 1, so each line is held for dwell+1 cycles.
REQ-020 In RUN with continuous mode, index SHALL wrap from 15 to 0 with no gap cycle.
REQ-021 In RUN with one-shot mode, the end of line 15's dwell SHALL transition to DONE; DONE lasts one cycle with done=1 and then returns to IDLE.
REQ-022 stop=1 in RUN SHALL transition to IDLE on the next edge, and the partial line SHALL NOT complete.
REQ-023 When start and stop are asserted in the same cycle, stop SHALL win.
REQ-024 start asserted in RUN or DONE SHALL be ignored.
REQ-025 A change to dwell or oneshot during RUN SHALL have no effect until the next start.
REQ-026 Outputs SHALL be registered and reflect the state and index of the current cycle, so the first line is visible on the cycle after start is sampled.
REQ-027 In RUN: num=index[2:0]; when index[3]=0, ic0_g1=1, ic0_g2b=0, ic1_g1=0 and ic1_g2b=1; when index[3]=1 the values are mirrored.
REQ-028 In IDLE and DONE, both decoders SHALL be disabled (g1=0, g2b=1), with num=0 and busy=0.
REQ-029 At most one decoder SHALL be enabled in any cycle, including the 7->8 and 15->0 transitions.
REQ-030 All counters SHALL be unsigned; the dwell counter is DWELL_W bits and SHALL NOT overflow, since its maximum equals dwell.

Reset
REQ-031 rst_n=0 SHALL immediately force: state=IDLE, index=0, dwell counter=0, num=0, ic0_g1=0, ic1_g1=0, ic0_g2b=1, ic1_g2b=1, busy=0, done=0.
REQ-032 Reset asserted mid-scan SHALL abort the scan with no done pulse.
REQ-033 After rst_n deasserts, the block SHALL stay in IDLE until start is sampled high.

Structure
REQ-034 The state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), LINES and the enable idle levels SHALL live in a shared package/include, scan_defs.
REQ-035 The dwell counter SHALL be a sub-module, dwell_timer, with inputs clk, rst_n, clear, limit and output expire.
REQ-036 The block SHALL connect to two ic74hc138 instances without glue logic.

Verification
REQ-037 Reset, then start with dwell=0 and oneshot=1: index SHALL go 0..15 on consecutive cycles, done SHALL pulse once the cycle after line 15, then the block returns to IDLE.
REQ-038 dwell=3, continuous: each line SHALL be held 4 cycles and index SHALL wrap 15->0 without a disabled cycle.
REQ-039 Decoder outputs checked over a full pass: exactly one of the 16 active-low lines SHALL be low each RUN cycle; all 16 SHALL be high in IDLE.
REQ-040 stop at index=9, mid-dwell: the next cycle SHALL show busy=0 and both decoders disabled, with no done pulse.
REQ-041 start and stop asserted together in IDLE: the block SHALL stay in IDLE; start asserted in RUN at index=5 SHALL NOT restart the scan.
REQ-042 rst_n dropped asynchronously between edges at index=12: the outputs SHALL reach their reset values before the next clk edge.
